updown_counter_7seg: RTL

UPDOWN_COUNTER_7SEG -- requirements
Module: updown_counter_7seg

---
 rtl/udc_pkg.sv | 31 +++
 rtl/bcd_to_7seg.sv | 34 +++
 rtl/updown_counter_7seg.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/udc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udc_pkg
//  Description : Shared definitions for the BCD up/down counter with
//                multiplexed 7-segment display: BCD digit width, segment
//                patterns {a,b,c,d,e,f,g} (active-high) and a nibble clamp.
//  Revision    : 1.0  initial release
// ============================================================================
package udc_pkg;

    localparam int c_bcd_w = 4;

    localparam logic [6:0] c_seg_0   = 7'b1111110;
    localparam logic [6:0] c_seg_1   = 7'b0110000;
    localparam logic [6:0] c_seg_2   = 7'b1101101;
    localparam logic [6:0] c_seg_3   = 7'b1111001;
    localparam logic [6:0] c_seg_4   = 7'b0110011;
    localparam logic [6:0] c_seg_5   = 7'b1011011;
    localparam logic [6:0] c_seg_6   = 7'b1011111;
    localparam logic [6:0] c_seg_7   = 7'b1110000;
    localparam logic [6:0] c_seg_8   = 7'b1111111;
    localparam logic [6:0] c_seg_9   = 7'b1111011;
    localparam logic [6:0] c_seg_off = 7'b0000000;

    // Force a nibble into BCD range; anything above 9 becomes 9.
    function automatic logic [c_bcd_w-1:0] clamp_bcd(input logic [c_bcd_w-1:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_7seg
//  Description : Combinational BCD digit to 7-segment decode.
//  Ports       : digit - BCD digit (0..9)
//                seg   - segments {a,b,c,d,e,f,g}, active-high
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_7seg
    import udc_pkg::*;
(
    input  logic [c_bcd_w-1:0] digit,
    output logic [6:0]         seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = c_seg_0;
            4'd1:    seg = c_seg_1;
            4'd2:    seg = c_seg_2;
            4'd3:    seg = c_seg_3;
            4'd4:    seg = c_seg_4;
            4'd5:    seg = c_seg_5;
            4'd6:    seg = c_seg_6;
            4'd7:    seg = c_seg_7;
            4'd8:    seg = c_seg_8;
            4'd9:    seg = c_seg_9;
            // The counter never holds a non-BCD nibble; blank just in case.
            default: seg = c_seg_off;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/updown_counter_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_7seg
//  Description : DIGITS-digit BCD up/down counter with wrap or saturate
//                limits, parallel load, terminal-count pulse and a scanned
//                multiplexed 7-segment display driver.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                en, up, sat      - count enable, direction, saturate mode
//                load, din        - parallel BCD load (nibbles >9 load as 9)
//                state            - current BCD count
//                tc               - one-cycle pulse after a wrap
//                seg, dp, view    - registered display outputs
//  Revision    : 1.0  initial release
// ============================================================================
module updown_counter_7seg
    import udc_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up,
    input  logic                      sat,
    input  logic                      load,
    input  logic [c_bcd_w*DIGITS-1:0] din,
    output logic [c_bcd_w*DIGITS-1:0] state,
    output logic                      tc,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [DIGITS-1:0]         view
);

    localparam int c_w     = c_bcd_w * DIGITS;
    localparam int c_pre_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [c_w-1:0]     r_state;
    logic [c_w-1:0]     w_inc;
    logic [c_w-1:0]     w_dec;
    logic [c_w-1:0]     w_load;
    logic [c_w-1:0]     w_next;
    logic               w_at_max;
    logic               w_at_zero;
    logic               w_wrap;
    logic               r_tc;
    logic [c_pre_w-1:0] r_pre;
    logic [c_idx_w-1:0] r_idx;
    logic [c_bcd_w-1:0] w_sel;
    logic [DIGITS-1:0]  w_view;
    logic               w_dp;
    logic [6:0]         w_seg;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [DIGITS-1:0]  r_view;

    // Ripple BCD +1 / -1. At MAX the +1 ripple naturally yields all zeros and
    // at zero the -1 ripple yields all nines, so wrap needs no special case.
    always_comb begin : comb_bcd_arith
        logic               carry;
        logic               borrow;
        logic [c_bcd_w-1:0] d;
        carry     = 1'b1;
        borrow    = 1'b1;
        d         = '0;
        w_inc     = r_state;
        w_dec     = r_state;
        w_load    = '0;
        w_at_max  = 1'b1;
        w_at_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = r_state[k*c_bcd_w +: c_bcd_w];
            if (d != 4'd9) w_at_max  = 1'b0;
            if (d != 4'd0) w_at_zero = 1'b0;
            w_load[k*c_bcd_w +: c_bcd_w] = clamp_bcd(din[k*c_bcd_w +: c_bcd_w]);
            if (carry) begin
                if (d == 4'd9) begin
                    w_inc[k*c_bcd_w +: c_bcd_w] = 4'd0;
                end else begin
                    w_inc[k*c_bcd_w +: c_bcd_w] = d + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (d == 4'd0) begin
                    w_dec[k*c_bcd_w +: c_bcd_w] = 4'd9;
                end else begin
                    w_dec[k*c_bcd_w +: c_bcd_w] = d - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin : comb_next_state
        w_next = r_state;
        w_wrap = 1'b0;
        if (load) begin
            w_next = w_load;
        end else if (en) begin
            if (up) begin
                if (!(w_at_max && sat)) w_next = w_inc;
                w_wrap = w_at_max && !sat;
            end else begin
                if (!(w_at_zero && sat)) w_next = w_dec;
                w_wrap = w_at_zero && !sat;
            end
        end
    end

    always_ff @(posedge clk) begin : ff_counter
        if (reset) begin
            r_state <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tc    <= w_wrap;
        end
    end

    // Free-running digit scan; untouched by en, load and sat.
    always_ff @(posedge clk) begin : ff_scan
        if (reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == c_pre_w'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == c_idx_w'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_comb begin : comb_digit_select
        w_sel  = '0;
        w_view = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_sel     = r_state[k*c_bcd_w +: c_bcd_w];
                w_view[k] = 1'b1;
            end
        end
    end

    // Decimal point flags "at the limit in the current direction" on digit 0.
    assign w_dp = (r_idx == '0) && (up ? w_at_max : w_at_zero);

    bcd_to_7seg u_decode (
        .digit (w_sel),
        .seg   (w_seg)
    );

    always_ff @(posedge clk) begin : ff_display
        if (reset) begin
            r_view <= DIGITS'(1);
            r_seg  <= c_seg_0;
            r_dp   <= 1'b0;
        end else begin
            r_view <= w_view;
            r_seg  <= w_seg;
            r_dp   <= w_dp;
        end
    end

    assign state = r_state;
    assign tc    = r_tc;
    assign seg   = r_seg;
    assign dp    = r_dp;
    assign view  = r_view;

endmodule
`default_nettype wire
